// File: rtl/riscv_multicycle_core.sv
// -----------------------------------------------------------------------------
// riscv_multicycle_core
//
// Multi-cycle RV32/RV64 integer core. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) through one shared datapath.
// Instruction and data memories are external, behind request/ready ports,
// so any number of wait states is tolerated.
//
// Handshake (both memory ports): the core raises *_req and holds the
// address/data payload stable until the memory answers with *_ready in a
// cycle where *_req is high. Ready may arrive in the same cycle as the
// request (zero-wait). Ready seen while req is low is ignored.
//
// Parameters
//   XLEN      datapath / register width (32 or 64)
//   RESET_PC  PC loaded on reset (4-byte aligned)
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   imem_req/addr          fetch request, address = PC
//   imem_ready/rdata       fetch complete, 32-bit instruction word
//   dmem_req/we/addr/wdata data request (we=1 store), addr = rs1 + imm
//   dmem_ready/rdata       data access complete, load data
//   retire                 1-cycle pulse in the last cycle of an instruction
//   halted                 sticky flag, set after an illegal instruction
//   pc_out                 current PC
//   dbg_state              current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module riscv_multicycle_core #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted,
    output logic [XLEN-1:0] pc_out,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Only the native-width load/store is legal: ld/sd on RV64, lw/sw on RV32.
    localparam logic [2:0]      C_F3_MEM = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam logic [XLEN-1:0] C_FOUR   = XLEN'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_next_state;

    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;      // rs1 value latched in DECODE
    logic [XLEN-1:0] r_b;      // rs2 value latched in DECODE
    logic [XLEN-1:0] r_imm;    // sign-extended immediate latched in DECODE
    logic [XLEN-1:0] r_alu;    // ALU result / effective address from EXEC
    logic [XLEN-1:0] r_mdr;    // load data latched in MEM
    logic [XLEN-1:0] r_regs [0:31];

    // ------------------------------------------------------------------
    // Instruction fields (IR is stable from DECODE until the next fetch)
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [2:0] w_f3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [6:0] w_f7;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    logic w_is_r;
    logic w_is_load;
    logic w_is_store;
    logic w_is_beq;

    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_load  = (w_opcode == OP_LOAD);
    assign w_is_store = (w_opcode == OP_STORE);
    assign w_is_beq   = (w_opcode == OP_BRANCH);

    // Legality decode: anything outside the supported subset halts the core.
    logic w_legal;

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_legal = ((w_f3 == 3'b000) && ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000)))
                       || (((w_f3 == 3'b111) || (w_f3 == 3'b110)) && (w_f7 == 7'b0000000));
            end
            OP_IMM:             w_legal = (w_f3 == 3'b000);
            OP_LOAD, OP_STORE:  w_legal = (w_f3 == C_F3_MEM);
            OP_BRANCH:          w_legal = (w_f3 == 3'b000);
            default:            w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Immediates. immB already carries its implicit zero LSB, so it is
    // added to the PC as-is with no further shift.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm;

    assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    always_comb begin
        w_imm = w_imm_i;
        if (w_is_store) begin
            w_imm = w_imm_s;
        end else if (w_is_beq) begin
            w_imm = w_imm_b;
        end
    end

    // Register file read; x0 always reads as zero.
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

    // ------------------------------------------------------------------
    // ALU. Non-R instructions (addi, load, store) all need rs1 + imm.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_alu;

    always_comb begin
        w_alu = r_a + r_imm;
        if (w_is_r) begin
            case (w_f3)
                3'b111:  w_alu = r_a & r_b;
                3'b110:  w_alu = r_a | r_b;
                default: w_alu = w_f7[5] ? (r_a - r_b) : (r_a + r_b);
            endcase
        end
    end

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_br_target;
    logic            w_taken;

    assign w_pc_plus4  = r_pc + C_FOUR;
    assign w_br_target = r_pc + r_imm;
    assign w_taken     = (r_a == r_b);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake/retire outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        retire       = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next_state = w_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (w_is_beq) begin
                    retire       = 1'b1;
                    w_next_state = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ready) begin
                    if (w_is_store) begin
                        retire       = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                retire       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Reset has priority, so a reset edge cancels any
    // register write or PC update that the current state would have made.
    // The MEM payload (r_alu, r_b) is not touched in MEM, which keeps the
    // request stable for as long as the memory stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_alu <= '0;
            r_mdr <= '0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir <= imem_rdata;
                    end
                end
                S_DECODE: begin
                    r_a   <= w_rs1_val;
                    r_b   <= w_rs2_val;
                    r_imm <= w_imm;
                end
                S_EXEC: begin
                    if (w_is_beq) begin
                        r_pc <= w_taken ? w_br_target : w_pc_plus4;
                    end else begin
                        r_alu <= w_alu;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_is_store) begin
                            r_pc <= w_pc_plus4;
                        end else begin
                            r_mdr <= dmem_rdata;
                        end
                    end
                end
                S_WB: begin
                    if (w_rd != 5'd0) begin
                        r_regs[w_rd] <= w_is_load ? r_mdr : r_alu;
                    end
                    r_pc <= w_pc_plus4;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr  = r_pc;
    assign dmem_addr  = r_alu;
    assign dmem_wdata = r_b;
    assign halted     = (r_state == S_HALT);
    assign pc_out     = r_pc;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// -----------------------------------------------------------------------------
// tb_riscv_multicycle_core
//
// Directed bench for riscv_multicycle_core (XLEN = 64, RESET_PC = 0).
// The bench plays both memories: it answers fetches with a hand-encoded
// instruction and data requests with a programmable number of wait cycles.
// Register contents are observed through stores (dmem_wdata).
// -----------------------------------------------------------------------------
module tb_riscv_multicycle_core;

    localparam int XLEN = 64;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;
    logic            retire;
    logic            halted;
    logic [XLEN-1:0] pc_out;
    logic [2:0]      dbg_state;

    always #5 clk = ~clk;

    riscv_multicycle_core #(
        .XLEN     (XLEN),
        .RESET_PC (64'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .halted     (halted),
        .pc_out     (pc_out),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int              tests_run    = 0;
    int              tests_failed = 0;
    logic [XLEN-1:0] exp_q [$];

    // Captured data-port activity of the last instruction.
    logic            cap_seen;
    logic            cap_stable;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic            cap_we;
    int              extra_req;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Starts at a negedge with the core in FETCH. Supplies 'inst' after
    // 'iwait' stall cycles, answers a data request after 'dwait' stall
    // cycles, and returns at the negedge following retire. While a request
    // is low its ready line is driven high with junk data, which the core
    // must ignore. exp_cyc = -1 means no retire is expected within 30 cycles.
    task automatic run(input string tag, input logic [31:0] inst, input logic [63:0] exp_fa,
                       input int iwait, input int dwait, input logic [63:0] rdata,
                       input int exp_cyc);
        int   cyc;
        int   iw;
        int   dw;
        logic fa_ok;
        logic fetched;
        cyc = -1; iw = 0; dw = 0; fa_ok = 1'b1; fetched = 1'b0;
        cap_seen = 1'b0; cap_stable = 1'b1; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
        extra_req = 0;
        for (int k = 1; k <= 30; k++) begin
            if (imem_req) begin
                if (fetched) begin
                    extra_req++;
                end else if (imem_addr !== exp_fa) begin
                    fa_ok = 1'b0;
                end
                if (iw == iwait) begin
                    imem_ready = 1'b1;
                    imem_rdata = inst;
                    fetched    = 1'b1;
                end else begin
                    imem_ready = 1'b0;
                    imem_rdata = 32'h0000007F;
                    iw++;
                end
            end else begin
                imem_ready = 1'b1;
                imem_rdata = 32'h0000007F;
            end
            if (dmem_req) begin
                if (!cap_seen) begin
                    cap_seen  = 1'b1;
                    cap_addr  = dmem_addr;
                    cap_wdata = dmem_wdata;
                    cap_we    = dmem_we;
                end else if (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata || dmem_we !== cap_we) begin
                    cap_stable = 1'b0;
                end
                if (dw == dwait) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdata;
                end else begin
                    dmem_ready = 1'b0;
                    dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    dw++;
                end
            end else begin
                dmem_ready = 1'b1;
                dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            #1;
            if (retire) begin
                cyc = k;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        chk({tag, "_fetch_addr"}, {63'd0, fa_ok}, 64'd1);
        chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic store_chk(input string tag, input logic [63:0] exp_addr);
        logic [63:0] exp_w;
        exp_w = exp_q.pop_front();
        chk({tag, "_addr"}, cap_addr, exp_addr);
        chk({tag, "_we"}, {63'd0, cap_we}, 64'd1);
        chk({tag, "_wdata"}, cap_wdata, exp_w);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_imem_req",  {63'd0, imem_req}, 64'd1);
        chk("rst_imem_addr", imem_addr, 64'h0);
        chk("rst_dmem_req",  {63'd0, dmem_req}, 64'd0);
        chk("rst_dmem_we",   {63'd0, dmem_we},  64'd0);
        chk("rst_retire",    {63'd0, retire},   64'd0);
        chk("rst_halted",    {63'd0, halted},   64'd0);
        chk("rst_pc",        pc_out, 64'h0);

        // ALU instructions, zero-wait: 4 cycles each
        run("addi_x1", 32'h00500093, 64'h00, 0, 0, 64'h0, 4);   // x1 = 5
        run("addi_x2", 32'hFFD00113, 64'h04, 0, 0, 64'h0, 4);   // x2 = -3
        run("add_x3",  32'h002081B3, 64'h08, 0, 0, 64'h0, 4);   // x3 = 2
        chk("pc_after_3", pc_out, 64'h0C);
        run("sub_x4",  32'h40110233, 64'h0C, 0, 0, 64'h0, 4);   // x4 = -8
        run("addi_x0", 32'h00700013, 64'h10, 0, 0, 64'h0, 4);   // x0 stays 0
        run("and_x6",  32'h0020F333, 64'h14, 0, 0, 64'h0, 4);   // x6 = 5
        run("or_x7",   32'h0020E3B3, 64'h18, 2, 0, 64'h0, 6);   // x7 = -3, 2 fetch waits

        exp_q.push_back(64'd2);
        run("sd_x3", 32'h00303023, 64'h1C, 0, 0, 64'h0, 4);     // sd x3,0(x0)
        store_chk("sd_x3", 64'd0);

        // beq x1,x1,-8 at 0x20 -> 0x18
        run("beq_taken", 32'hFE108CE3, 64'h20, 0, 0, 64'h0, 3);
        chk("beq_taken_pc", pc_out, 64'h18);
        chk("beq_taken_nodmem", {63'd0, cap_seen}, 64'd0);

        exp_q.push_back(64'd5);
        run("sd_x6", 32'h02603023, 64'h18, 0, 0, 64'h0, 4);     // sd x6,32(x0)
        store_chk("sd_x6", 64'd32);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        run("sd_x7", 32'h02703423, 64'h1C, 0, 0, 64'h0, 4);     // sd x7,40(x0)
        store_chk("sd_x7", 64'd40);

        // beq x1,x2,+12 at 0x20, not taken -> 0x24
        run("beq_nt", 32'h00208663, 64'h20, 0, 0, 64'h0, 3);
        chk("beq_nt_pc", pc_out, 64'h24);

        // Store then load with 3 data wait cycles
        exp_q.push_back(64'd5);
        run("sd_x1_wait", 32'h00103823, 64'h24, 0, 3, 64'h0, 7);
        store_chk("sd_x1_wait", 64'd16);
        chk("sd_x1_wait_stable", {63'd0, cap_stable}, 64'd1);
        run("ld_x5_wait", 32'h01003283, 64'h28, 0, 3, 64'd5, 8);
        chk("ld_x5_wait_addr", cap_addr, 64'd16);
        chk("ld_x5_wait_we", {63'd0, cap_we}, 64'd0);
        chk("ld_x5_wait_stable", {63'd0, cap_stable}, 64'd1);

        exp_q.push_back(64'd5);
        run("sd_x5", 32'h00503C23, 64'h2C, 0, 0, 64'h0, 4);     // sd x5,24(x0)
        store_chk("sd_x5", 64'd24);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        run("sd_x4", 32'h00403423, 64'h30, 0, 0, 64'h0, 4);     // sd x4,8(x0)
        store_chk("sd_x4", 64'd8);
        exp_q.push_back(64'd0);
        run("sd_x0", 32'h00003023, 64'h34, 0, 0, 64'h0, 4);     // sd x0,0(x0)
        store_chk("sd_x0", 64'd0);
        chk("pc_before_mem_reset", pc_out, 64'h38);

        // Reset while a load sits in MEM with its request high
        chk("memrst_fetch_addr", imem_addr, 64'h38);
        imem_ready = 1'b1;
        imem_rdata = 32'h01003083;                              // ld x1,16(x0)
        @(negedge clk);                                         // DECODE
        imem_ready = 1'b0;
        @(negedge clk);                                         // EXEC
        @(negedge clk);                                         // MEM
        chk("memrst_dmem_req_before", {63'd0, dmem_req}, 64'd1);
        dmem_ready = 1'b1;
        dmem_rdata = 64'h99;
        reset      = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        dmem_ready = 1'b0;
        chk("memrst_dmem_req", {63'd0, dmem_req}, 64'd0);
        chk("memrst_imem_req", {63'd0, imem_req}, 64'd1);
        chk("memrst_imem_addr", imem_addr, 64'h0);
        chk("memrst_retire", {63'd0, retire}, 64'd0);
        exp_q.push_back(64'd0);
        run("memrst_sd_x1", 32'h00103023, 64'h00, 0, 0, 64'h0, 4);   // sd x1,0(x0)
        store_chk("memrst_sd_x1", 64'd0);

        // Illegal opcode 0x7F halts after DECODE
        run("illegal_7f", 32'h0000007F, 64'h04, 0, 0, 64'h0, -1);
        chk("halt_flag", {63'd0, halted}, 64'd1);
        chk("halt_no_refetch", 64'(extra_req), 64'd0);
        chk("halt_no_dmem", {63'd0, cap_seen}, 64'd0);
        chk("halt_pc", pc_out, 64'h04);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("unhalt_flag", {63'd0, halted}, 64'd0);
        chk("unhalt_imem_req", {63'd0, imem_req}, 64'd1);
        chk("unhalt_imem_addr", imem_addr, 64'h0);

        // Zero-wait load (5 cycles) and store (4 cycles)
        run("ld_x5_zw", 32'h01003283, 64'h00, 0, 0, 64'h1234_5678_9ABC_DEF0, 5);
        chk("ld_x5_zw_addr", cap_addr, 64'd16);
        exp_q.push_back(64'h1234_5678_9ABC_DEF0);
        run("sd_x5_zw", 32'h00503C23, 64'h04, 0, 0, 64'h0, 4);
        store_chk("sd_x5_zw", 64'd24);

        // Illegal funct3 on an R-type (sll) also halts
        run("illegal_sll", 32'h002091B3, 64'h08, 0, 0, 64'h0, -1);
        chk("halt_sll_flag", {63'd0, halted}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
